// File: rtl/core_ctrl_regfile_pkg.sv
// Shared register map, IRQ command encodings and helpers for the core control register file.
// The watchdog offsets are only decoded when CORE_CTRL_WDT_EN is defined.
package core_ctrl_regfile_pkg;

  localparam int unsigned TcuRegDataSize = 64;
  localparam int unsigned TcuRegBselSize = 8;
  localparam int unsigned TcuRegAddrSize = 32;

  localparam logic [TcuRegAddrSize-1:0] AddrCoreEn     = 32'h00;
  localparam logic [TcuRegAddrSize-1:0] AddrIrqBase    = 32'h08;
  localparam logic [TcuRegAddrSize-1:0] AddrErrBase    = 32'h30;
  localparam logic [TcuRegAddrSize-1:0] AddrTraceEn    = 32'h40;
  localparam logic [TcuRegAddrSize-1:0] AddrTracePtr   = 32'h48;
  localparam logic [TcuRegAddrSize-1:0] AddrTraceCount = 32'h50;
  localparam logic [TcuRegAddrSize-1:0] AddrErrMask    = 32'h58;
  localparam logic [TcuRegAddrSize-1:0] AddrWdtLimit   = 32'h60;
  localparam logic [TcuRegAddrSize-1:0] AddrWdtKick    = 32'h68;
  localparam logic [TcuRegAddrSize-1:0] AddrWdtStatus  = 32'h70;

  // IRQ commands: 00 clear, 01 set level, 1x start pulse.
  localparam logic [1:0] IrqCmdClear = 2'b00;
  localparam logic [1:0] IrqCmdLevel = 2'b01;

  function automatic logic [TcuRegDataSize-1:0] byte_mask(input logic [TcuRegBselSize-1:0] wben);
    logic [TcuRegDataSize-1:0] m;
    for (int b = 0; b < int'(TcuRegBselSize); b++) m[b*8 +: 8] = {8{wben[b]}};
    return m;
  endfunction

endpackage

// File: rtl/core_ctrl_regfile_if.sv
// TCU register access bus: strobe, byte enables, address, write data and registered read data.
interface core_ctrl_regfile_if;
  import core_ctrl_regfile_pkg::*;

  logic                      config_en;
  logic [TcuRegBselSize-1:0] config_wben;
  logic [TcuRegAddrSize-1:0] config_addr;
  logic [TcuRegDataSize-1:0] config_wdata;
  logic [TcuRegDataSize-1:0] config_rdata;

  modport master (
    output config_en, config_wben, config_addr, config_wdata,
    input  config_rdata
  );

  modport slave (
    input  config_en, config_wben, config_addr, config_wdata,
    output config_rdata
  );
endinterface

// File: rtl/core_ctrl_regfile_irq_gen.sv
// One external interrupt line: a level bit plus a down-counting pulse timer.
module core_ctrl_irq_gen
  import core_ctrl_regfile_pkg::*;
#(
    parameter int unsigned IRQ_PULSE_LEN = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       irq,
    output logic [1:0] status
);

  localparam int unsigned CntW = $clog2(IRQ_PULSE_LEN + 1);
  localparam logic [CntW-1:0] PulseLen = CntW'(IRQ_PULSE_LEN);

  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
    if (cmd_valid) begin
      if (cmd[1]) begin
        cnt_d   = PulseLen;
        level_d = 1'b0;
      end else if (cmd == IrqCmdLevel) begin
        level_d = 1'b1;
      end else if (cmd == IrqCmdClear) begin
        level_d = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign irq    = level_q | (cnt_q != '0);
  assign status = {cnt_q != '0, level_q};

endmodule

// File: rtl/core_ctrl_regfile.sv
// Per-tile core control register file: core enable, interrupt lines, sticky errors, trace control.
// Define CORE_CTRL_WDT_EN to add the watchdog at 0x60/0x68/0x70.
module core_ctrl_regfile
  import core_ctrl_regfile_pkg::*;
#(
    parameter int unsigned NUM_IRQ       = 2,
    parameter int unsigned NUM_ERR_SRC   = 2,
    parameter int unsigned ERR_WIDTH     = 32,
    parameter int unsigned IRQ_PULSE_LEN = 16,
    parameter int unsigned MEM_ADDR_SIZE = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    core_ctrl_regfile_if.slave                 cfg,
    output logic                               core_en_o,
    output logic [NUM_IRQ-1:0]                 core_irq_o,
    output logic                               err_irq_o,
    input  logic [NUM_ERR_SRC*ERR_WIDTH-1:0]   err_i,
    output logic                               trace_en_o,
    input  logic [MEM_ADDR_SIZE-1:0]           trace_ptr_i,
    input  logic [MEM_ADDR_SIZE-1:0]           trace_count_i
);

  localparam int unsigned MaskW = NUM_ERR_SRC * ERR_WIDTH;

  logic                      wr_en, rd_en;
  logic [TcuRegAddrSize-1:0] addr;
  logic [TcuRegDataSize-1:0] byte_en_mask, wdata_bm;

  assign addr         = cfg.config_addr;
  assign wr_en        = cfg.config_en && (cfg.config_wben != '0);
  assign rd_en        = cfg.config_en && (cfg.config_wben == '0);
  assign byte_en_mask = byte_mask(cfg.config_wben);
  assign wdata_bm     = cfg.config_wdata & byte_en_mask;

  logic                                   core_en_q, core_en_d, trace_en_q, trace_en_d;
  logic                                   err_irq_q, err_irq_d;
  logic [MaskW-1:0]                       mask_q, mask_d, sticky_flat;
  logic [NUM_ERR_SRC-1:0][ERR_WIDTH-1:0]  sticky_q, sticky_d, err_clr;
  logic [TcuRegDataSize-1:0]              rdata_q, rdata_d;
  logic [NUM_IRQ-1:0][1:0]                irq_status;
  logic                                   wdt_expired;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
    logic cmd_valid;
    assign cmd_valid = wr_en && cfg.config_wben[0] &&
                       (addr == AddrIrqBase + TcuRegAddrSize'(8 * i));
    core_ctrl_irq_gen #(
      .IRQ_PULSE_LEN(IRQ_PULSE_LEN)
    ) u_irq_gen (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .cmd_valid(cmd_valid),
      .cmd      (cfg.config_wdata[1:0]),
      .irq      (core_irq_o[i]),
      .status   (irq_status[i])
    );
  end

`ifdef CORE_CTRL_WDT_EN
  logic [31:0] wdt_limit_q, wdt_limit_d, wdt_cnt_q, wdt_cnt_d;
  logic        wdt_exp_q, wdt_exp_d, wdt_hit, wdt_kick;

  always_comb begin
    wdt_limit_d = wdt_limit_q;
    if (wr_en && addr == AddrWdtLimit) begin
      wdt_limit_d = (wdt_limit_q & ~byte_en_mask[31:0]) | wdata_bm[31:0];
    end
    wdt_kick  = wr_en && (addr == AddrWdtKick);
    wdt_hit   = 1'b0;
    wdt_cnt_d = wdt_cnt_q;
    // Kick takes priority over an expiry in the same cycle; the count saturates at the limit.
    if (!core_en_q || wdt_kick) begin
      wdt_cnt_d = '0;
    end else if (wdt_limit_q != '0) begin
      if ({1'b0, wdt_cnt_q} + 33'd1 >= {1'b0, wdt_limit_q}) begin
        wdt_cnt_d = wdt_limit_q;
        wdt_hit   = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 32'd1;
      end
    end
    wdt_exp_d = wdt_exp_q;
    if (wr_en && addr == AddrWdtStatus && cfg.config_wben[0] && cfg.config_wdata[0]) begin
      wdt_exp_d = 1'b0;
    end
    if (wdt_hit) wdt_exp_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wdt_limit_q <= '0;
      wdt_cnt_q   <= '0;
      wdt_exp_q   <= 1'b0;
    end else begin
      wdt_limit_q <= wdt_limit_d;
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_exp_q   <= wdt_exp_d;
    end
  end

  assign wdt_expired = wdt_exp_q;
`else
  assign wdt_expired = 1'b0;
`endif

  assign sticky_flat = sticky_q;

  always_comb begin
    core_en_d  = core_en_q;
    trace_en_d = trace_en_q;
    mask_d     = mask_q;
    if (wr_en && cfg.config_wben[0] && addr == AddrCoreEn)  core_en_d  = cfg.config_wdata[0];
    if (wr_en && cfg.config_wben[0] && addr == AddrTraceEn) trace_en_d = cfg.config_wdata[0];
    if (wr_en && addr == AddrErrMask) begin
      mask_d = (mask_q & ~byte_en_mask[MaskW-1:0]) | wdata_bm[MaskW-1:0];
    end
    // New error bits win over a W1C clear landing in the same cycle.
    for (int unsigned j = 0; j < NUM_ERR_SRC; j++) begin
      err_clr[j] = (wr_en && addr == AddrErrBase + TcuRegAddrSize'(8 * j)) ?
                   wdata_bm[ERR_WIDTH-1:0] : '0;
      sticky_d[j] = (sticky_q[j] & ~err_clr[j]) | err_i[j*ERR_WIDTH +: ERR_WIDTH];
    end
    err_irq_d = (|(sticky_flat & mask_q)) | wdt_expired;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      if (addr == AddrCoreEn)     rdata_d[0] = core_en_q;
      if (addr == AddrTraceEn)    rdata_d[0] = trace_en_q;
      if (addr == AddrTracePtr)   rdata_d[MEM_ADDR_SIZE-1:0] = trace_ptr_i;
      if (addr == AddrTraceCount) rdata_d[MEM_ADDR_SIZE-1:0] = trace_count_i;
      if (addr == AddrErrMask)    rdata_d[MaskW-1:0] = mask_q;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (addr == AddrIrqBase + TcuRegAddrSize'(8 * i)) rdata_d[1:0] = irq_status[i];
      end
      for (int unsigned j = 0; j < NUM_ERR_SRC; j++) begin
        if (addr == AddrErrBase + TcuRegAddrSize'(8 * j)) rdata_d[ERR_WIDTH-1:0] = sticky_q[j];
      end
`ifdef CORE_CTRL_WDT_EN
      if (addr == AddrWdtLimit)  rdata_d[31:0] = wdt_limit_q;
      if (addr == AddrWdtStatus) rdata_d = {wdt_cnt_q, 31'd0, wdt_exp_q};
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_en_q  <= 1'b0;
      trace_en_q <= 1'b0;
      mask_q     <= '0;
      sticky_q   <= '0;
      err_irq_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      core_en_q  <= core_en_d;
      trace_en_q <= trace_en_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      err_irq_q  <= err_irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign core_en_o        = core_en_q;
  assign trace_en_o       = trace_en_q;
  assign err_irq_o        = err_irq_q;
  assign cfg.config_rdata = rdata_q;

endmodule

// File: tb/tb_core_ctrl_regfile.sv
// Randomised and directed bench for core_ctrl_regfile against a register-level behavioural model.
module tb_core_ctrl_regfile;

  localparam int unsigned NIrq     = 2;
  localparam int unsigned NErr     = 2;
  localparam int unsigned ErrW     = 32;
  localparam int unsigned PulseLen = 16;
  localparam int unsigned MemW     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_ctrl_regfile_if cfg ();

  logic                   core_en, err_irq, trace_en;
  logic [NIrq-1:0]        core_irq;
  logic [NErr*ErrW-1:0]   err_in;
  logic [MemW-1:0]        trace_ptr, trace_count;

  core_ctrl_regfile #(
    .NUM_IRQ      (NIrq),
    .NUM_ERR_SRC  (NErr),
    .ERR_WIDTH    (ErrW),
    .IRQ_PULSE_LEN(PulseLen),
    .MEM_ADDR_SIZE(MemW)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .cfg          (cfg),
    .core_en_o    (core_en),
    .core_irq_o   (core_irq),
    .err_irq_o    (err_irq),
    .err_i        (err_in),
    .trace_en_o   (trace_en),
    .trace_ptr_i  (trace_ptr),
    .trace_count_i(trace_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  bit          m_core_en, m_trace_en, m_err_irq;
  bit          m_lvl[NIrq];
  int          m_rem[NIrq];
  logic [ErrW-1:0] m_sticky[NErr];
  logic [63:0] m_mask, m_rdata;
  logic [31:0] m_wdt_limit, m_wdt_cnt;
  bit          m_wdt_exp;

  function automatic logic [63:0] bytes_to_mask(input logic [7:0] wben);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = wben[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    if (a == 32'h00) return 64'(m_core_en);
    if (a == 32'h40) return 64'(m_trace_en);
    if (a == 32'h48) return 64'(trace_ptr);
    if (a == 32'h50) return 64'(trace_count);
    if (a == 32'h58) return m_mask;
    for (int i = 0; i < int'(NIrq); i++)
      if (a == 32'(8 + 8 * i)) return 64'({m_rem[i] > 0, m_lvl[i]});
    for (int j = 0; j < int'(NErr); j++)
      if (a == 32'(48 + 8 * j)) return 64'(m_sticky[j]);
`ifdef CORE_CTRL_WDT_EN
    if (a == 32'h60) return 64'(m_wdt_limit);
    if (a == 32'h70) return {m_wdt_cnt, 31'd0, m_wdt_exp};
`endif
    return 64'd0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit          wr, rd, err_irq_next;
    logic [63:0] bm, wd, acc;
    logic [31:0] a;
    logic [ErrW-1:0] clr;
    a  = cfg.config_addr;
    wr = cfg.config_en && (cfg.config_wben != 0);
    rd = cfg.config_en && (cfg.config_wben == 0);
    bm = bytes_to_mask(cfg.config_wben);
    wd = cfg.config_wdata & bm;
    acc = 0;
    for (int j = 0; j < int'(NErr); j++) acc[j*ErrW +: ErrW] = m_sticky[j] & m_mask[j*ErrW +: ErrW];
    err_irq_next = (acc != 0) || m_wdt_exp;
    if (rd) m_rdata = model_read(a);
`ifdef CORE_CTRL_WDT_EN
    begin
      bit hit;
      hit = 0;
      if (!m_core_en || (wr && a == 32'h68)) m_wdt_cnt = 0;
      else if (m_wdt_limit != 0) begin
        if (longint'(m_wdt_cnt) + 1 >= longint'(m_wdt_limit)) begin
          m_wdt_cnt = m_wdt_limit;
          hit = 1;
        end else m_wdt_cnt = m_wdt_cnt + 1;
      end
      if (wr && a == 32'h70 && cfg.config_wben[0] && cfg.config_wdata[0]) m_wdt_exp = 0;
      if (hit) m_wdt_exp = 1;
      if (wr && a == 32'h60) m_wdt_limit = (m_wdt_limit & ~bm[31:0]) | wd[31:0];
    end
`endif
    for (int i = 0; i < int'(NIrq); i++) begin
      if (m_rem[i] > 0) m_rem[i]--;
      if (wr && cfg.config_wben[0] && a == 32'(8 + 8 * i)) begin
        if (cfg.config_wdata[1]) begin
          m_rem[i] = PulseLen;
          m_lvl[i] = 0;
        end else if (cfg.config_wdata[0]) m_lvl[i] = 1;
        else begin
          m_lvl[i] = 0;
          m_rem[i] = 0;
        end
      end
    end
    for (int j = 0; j < int'(NErr); j++) begin
      clr = (wr && a == 32'(48 + 8 * j)) ? wd[ErrW-1:0] : '0;
      m_sticky[j] = (m_sticky[j] & ~clr) | err_in[j*ErrW +: ErrW];
    end
    if (wr && a == 32'h58) m_mask = (m_mask & ~bm) | wd;
    if (wr && cfg.config_wben[0] && a == 32'h00) m_core_en = cfg.config_wdata[0];
    if (wr && cfg.config_wben[0] && a == 32'h40) m_trace_en = cfg.config_wdata[0];
    m_err_irq = err_irq_next;
  endtask

  task automatic tick();
    logic [NIrq-1:0] exp_irq;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < int'(NIrq); i++) exp_irq[i] = m_lvl[i] || (m_rem[i] > 0);
    check_eq("core_en", 64'(core_en), 64'(m_core_en));
    check_eq("trace_en", 64'(trace_en), 64'(m_trace_en));
    check_eq("core_irq", 64'(core_irq), 64'(exp_irq));
    check_eq("err_irq", 64'(err_irq), 64'(m_err_irq));
    check_eq("rdata", cfg.config_rdata, m_rdata);
  endtask

  task automatic op(input bit en, input logic [7:0] wben, input logic [31:0] a,
                    input logic [63:0] d, input logic [NErr*ErrW-1:0] e);
    cfg.config_en    = en;
    cfg.config_wben  = wben;
    cfg.config_addr  = a;
    cfg.config_wdata = d;
    err_in           = e;
    tick();
    cfg.config_en    = 1'b0;
    cfg.config_wben  = '0;
    err_in           = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    op(1'b1, 8'hFF, a, d, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    op(1'b1, 8'h00, a, 64'd0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) op(1'b0, 8'h00, 32'h0, 64'd0, '0);
  endtask

  logic [31:0] addrs[15] = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h30, 32'h38, 32'h40,
                             32'h48, 32'h50, 32'h58, 32'h60, 32'h68, 32'h70, 32'h78};

  initial begin
    int n_high;
    cfg.config_en    = 1'b0;
    cfg.config_wben  = '0;
    cfg.config_addr  = '0;
    cfg.config_wdata = '0;
    err_in           = '0;
    trace_ptr        = '0;
    trace_count      = '0;
    m_core_en = 0; m_trace_en = 0; m_err_irq = 0; m_mask = 0; m_rdata = 0;
    m_wdt_limit = 0; m_wdt_cnt = 0; m_wdt_exp = 0;
    for (int i = 0; i < int'(NIrq); i++) begin m_lvl[i] = 0; m_rem[i] = 0; end
    for (int j = 0; j < int'(NErr); j++) m_sticky[j] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_core_en", 64'(core_en), 64'd0);
    check_eq("rst_core_irq", 64'(core_irq), 64'd0);
    check_eq("rst_err_irq", 64'(err_irq), 64'd0);
    check_eq("rst_trace_en", 64'(trace_en), 64'd0);
    check_eq("rst_rdata", cfg.config_rdata, 64'd0);
    rst_n = 1'b1;

    rd(32'h00);
    check_eq("rd_core_en", cfg.config_rdata, 64'd0);

    // Single pulse, then a pulse restarted on its tenth high cycle.
    wr(32'h08, 64'h2);
    n_high = int'(core_irq[0]);
    for (int k = 0; k < 40; k++) begin idle(1); n_high += int'(core_irq[0]); end
    check_eq("pulse_len", 64'(n_high), 64'(PulseLen));
    wr(32'h08, 64'h2);
    n_high = int'(core_irq[0]);
    for (int k = 0; k < 9; k++) begin idle(1); n_high += int'(core_irq[0]); end
    wr(32'h08, 64'h2);
    n_high += int'(core_irq[0]);
    for (int k = 0; k < 40; k++) begin idle(1); n_high += int'(core_irq[0]); end
    check_eq("pulse_restart_len", 64'(n_high), 64'(PulseLen + 10));

    wr(32'h10, 64'h1);
    check_eq("irq1_level", 64'(core_irq[1]), 64'd1);
    rd(32'h10);
    check_eq("rd_irq1", cfg.config_rdata, 64'h1);
    wr(32'h10, 64'h0);

    op(1'b0, 8'h00, 32'h0, 64'd0, 64'h5);
    rd(32'h30);
    check_eq("err_capture", cfg.config_rdata, 64'h5);
    wr(32'h30, 64'h1);
    rd(32'h30);
    check_eq("err_w1c", cfg.config_rdata, 64'h4);
    op(1'b1, 8'hFF, 32'h30, 64'h4, 64'h4);
    rd(32'h30);
    check_eq("err_set_wins", cfg.config_rdata, 64'h4);

    wr(32'h58, 64'h4);
    idle(1);
    check_eq("err_irq_masked_in", 64'(err_irq), 64'd1);
    wr(32'h58, 64'h0);
    idle(1);
    check_eq("err_irq_masked_out", 64'(err_irq), 64'd0);

    op(1'b1, 8'h01, 32'h58, 64'hFFFF, '0);
    rd(32'h58);
    check_eq("mask_byte_en", cfg.config_rdata, 64'hFF);
    wr(32'h58, 64'h0);

    trace_ptr   = 32'h1234_5678;
    trace_count = 32'h0000_0ABC;
    wr(32'h48, 64'hFFFF_FFFF);
    rd(32'h48);
    check_eq("trace_ptr_ro", cfg.config_rdata, 64'h1234_5678);
    rd(32'h50);
    check_eq("trace_count", cfg.config_rdata, 64'h0ABC);
    wr(32'h40, 64'h1);
    rd(32'h40);
    check_eq("trace_en_rd", cfg.config_rdata, 64'h1);
    rd(32'h78);
    check_eq("unmapped", cfg.config_rdata, 64'd0);
    wr(32'h18, 64'h1);
    rd(32'h18);
    check_eq("irq_unimpl", cfg.config_rdata, 64'd0);

`ifdef CORE_CTRL_WDT_EN
    wr(32'h00, 64'h1);
    wr(32'h60, 64'd100);
    idle(120);
    rd(32'h70);
    check_eq("wdt_expired", 64'(cfg.config_rdata[0]), 64'd1);
    check_eq("wdt_sat_count", 64'(cfg.config_rdata[63:32]), 64'd100);
    check_eq("wdt_err_irq", 64'(err_irq), 64'd1);
    wr(32'h68, 64'h0);
    wr(32'h70, 64'h1);
    idle(97);
    wr(32'h68, 64'h0);
    idle(97);
    rd(32'h70);
    check_eq("wdt_kicked", 64'(cfg.config_rdata[0]), 64'd0);
    wr(32'h00, 64'h0);
`else
    wr(32'h60, 64'h5);
    rd(32'h60);
    check_eq("wdt_absent", cfg.config_rdata, 64'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [7:0]  wb;
      logic [63:0] d, e;
      a  = addrs[$urandom_range(0, 14)];
      wb = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      d  = {$urandom, $urandom};
      if (a >= 32'h08 && a <= 32'h20) d = 64'($urandom_range(0, 3));
      e  = ($urandom_range(0, 5) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
      trace_ptr   = $urandom;
      trace_count = $urandom;
      op($urandom_range(0, 3) != 0, wb, a, d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_ctrl_regfile.md
Name: core_ctrl_regfile

Overview:
Parametrised next-generation per-tile core control register file, sitting between the TCU register interface and the attached core (BOOM, Rocket or others).
- Provides core enable.
- Provides NUM_IRQ external interrupt lines, each with level or auto-timed pulse mode.
- Holds NUM_ERR_SRC sticky write-1-to-clear error registers with a maskable error interrupt.
- Provides trace enable plus readback of the trace pointer and trace count.

Parameters:
NUM_IRQ, 2, number of external core interrupt lines (1..4)
NUM_ERR_SRC, 2, number of error status inputs (1..2)
ERR_WIDTH, 32, width of each error input (1..64)
IRQ_PULSE_LEN, 16, cycles a pulse-mode interrupt stays high (>=1)
MEM_ADDR_SIZE, 32, width of the trace pointer and trace count inputs

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
config_en_i  in  1  register access strobe
config_wben_i  in  TCU_REG_BSEL_SIZE  byte enables; nonzero = write, zero = read
config_addr_i  in  TCU_REG_ADDR_SIZE  register byte address
config_wdata_i  in  TCU_REG_DATA_SIZE  write data
config_rdata_o  out  TCU_REG_DATA_SIZE  registered read data
core_en_o  out  1  core enable
core_irq_o  out  NUM_IRQ  external interrupts
err_irq_o  out  1  OR of (sticky errors & mask)
err_i  in  NUM_ERR_SRC*ERR_WIDTH  error sources, bit-set pulses or levels
trace_en_o  out  1  trace enable
trace_ptr_i  in  MEM_ADDR_SIZE  trace write pointer
trace_count_i  in  MEM_ADDR_SIZE  trace entry count

Behaviour:
- Clock and reset: single clock clk_i. Asynchronous active-low reset reset_n_i clears every register, counter and output to 0.
- Access decode: write when config_en_i && |wben; read when config_en_i && !|wben.
- Read timing: 1-cycle latency. config_rdata_o is updated on the cycle after the read strobe and holds until the next read. Unmapped addresses and unimplemented IRQ or ERR indices read 0. Values are zero-extended.
- Byte enables: applied per byte for multi-bit registers. Single-bit controls use wben[0].
- Register map:
  - 0x00 CORE_EN: RW, bit0.
  - 0x08+8*i IRQ_i (i<NUM_IRQ): write wdata[1:0]:
    - 00: clear level and cancel any pulse.
    - 01: set level.
    - 1x: start pulse. Loads counter with IRQ_PULSE_LEN, clears level.
  - IRQ output: core_irq_o[i] = level | (cnt!=0). The counter decrements each cycle while nonzero, so a pulse lasts exactly IRQ_PULSE_LEN cycles starting the cycle after the write. A pulse write during an active pulse restarts the counter. Read returns {pulse_active, level}.
  - 0x30+8*j ERR_j: sticky, captured every cycle as sticky |= err_i slice. A write with data bit=1 clears that bit (W1C). If a clear and a new error bit land in the same cycle, set wins.
  - 0x40 TRACE_EN: RW, bit0.
  - 0x48 TRACE_PTR: RO.
  - 0x50 TRACE_COUNT: RO.
  - 0x58 ERR_MASK: RW, NUM_ERR_SRC*ERR_WIDTH bits, source j at bits [j*ERR_WIDTH+:ERR_WIDTH]. Total must be <=64.
- err_irq_o is registered and reflects the sticky and mask state of the previous cycle.
- Writes to RO or unmapped addresses are ignored. A read and a write never occur in the same cycle.

Optional Feature:
- Macro: CORE_CTRL_WDT_EN.
- When defined, adds a watchdog:
  - 0x60 WDT_LIMIT: RW, 32 bits.
  - 0x68 WDT_KICK: write of any value clears the counter.
  - 0x70 WDT_STATUS: bit0 sticky expired, W1C; bits[63:32] current count.
  - Counting: counts while core_en_o=1 and WDT_LIMIT!=0.
  - Expiry: when the count reaches WDT_LIMIT, the expired bit is set, the counter saturates, and err_irq_o is asserted unmasked.
  - Kick and expiry in the same cycle: kick wins.
  - Clearing CORE_EN resets the count.
- Without the macro: these addresses read 0 and writes are ignored; no counter logic is present.

Decomposition:
- Shared header core_ctrl_regs.vh: register offset localparams, the IRQ command encodings (00/01/1x), and the WDT offsets.
- One sub-module, core_ctrl_irq_gen, instantiated NUM_IRQ times: level/pulse generator holding the level bit and pulse counter, with inputs cmd_valid and cmd[1:0].

Test Plan:
- Reset with all inputs 0: all outputs 0. Read of 0x00 returns 0x0 one cycle later.
- IRQ pulse: write 0x2 to 0x08 with IRQ_PULSE_LEN=16 -> core_irq_o[0] high for exactly 16 cycles, then low. Rewrite at cycle 10 -> high for 26 cycles total.
- ERR capture and clear: err_i pulse 0x5 on source 0 -> read 0x30 returns 0x5. W1C 0x1 -> reads 0x4. W1C 0x4 in the same cycle as err_i=0x4 -> still 0x4.
- Error mask: ERR_MASK=0x4 with sticky 0x4 -> err_irq_o=1 next cycle. Mask 0x0 -> err_irq_o=0.
- Byte enables and RO registers: wben=0x01 to ERR_MASK with data 0xFFFF -> mask reads 0xFF. Write to 0x48 -> ignored; read returns trace_ptr_i. Unmapped 0x78 -> 0.
- CORE_CTRL_WDT_EN: core_en=1, LIMIT=100, no kick -> expired bit set at count 100, err_irq_o=1. Kick at cycle 99 -> no expiry.
